// File: rtl/video_pll_ctrl.sv
// video_pll_ctrl: supervises the video rPLL from the reference-clock domain.
// It sequences PLL reset, qualifies lock, releases the video reset, recovers
// from lock loss, and owns PSDA (phase shift) with a settle window before ack.
// Ports: clkin, reset (async, active-high), pll_lock (async, synchronised
//  here), ps_req/ps_val (phase request) in; pll_reset, pll_psda, ps_ack,
//  vid_rst, locked, fail, retry_cnt out.
// Optional: define VIDEO_PLL_LOSS_CNT_EN to add lock_loss_cnt[15:0], a
//  saturating count of lock-loss events seen in RUN/SETTLE.
module video_pll_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_STABLE   = 1024,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRY     = 3
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        pll_lock,
    input  logic        ps_req,
    input  logic [3:0]  ps_val,
    output logic        pll_reset,
    output logic [3:0]  pll_psda,
    output logic        ps_ack,
    output logic        vid_rst,
    output logic        locked,
    output logic        fail,
    output logic [1:0]  retry_cnt
`ifdef VIDEO_PLL_LOSS_CNT_EN
    ,
    output logic [15:0] lock_loss_cnt
`endif
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int CMAX = max2(max2(RST_CYCLES, LOCK_STABLE),
                               max2(LOCK_TIMEOUT, SETTLE_CYCLES));
    localparam int CW = $clog2(CMAX + 1);

    // The WAIT_LOCK sample that first sees lock counts toward the stable
    // window, so STABLE itself only needs LOCK_STABLE-1 further samples.
    localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_LAST = CW'((LOCK_STABLE > 1) ? LOCK_STABLE - 2 : 0);
    localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [1:0]    RETRY_LIM = 2'(MAX_RETRY);

    typedef enum logic [2:0] {
        ST_RST_PLL,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_RUN,
        ST_SETTLE,
        ST_FAIL
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    sync_q;
    logic          lock_s;
    logic          pll_reset_q, pll_reset_d;
    logic [3:0]    psda_q, psda_d;
    logic          ack_q, ack_d;
    logic          vid_rst_q, vid_rst_d;
    logic          locked_q, locked_d;
    logic          fail_q, fail_d;
    logic [1:0]    retry_q, retry_d;
    logic          req_done_q, req_done_d;
`ifdef VIDEO_PLL_LOSS_CNT_EN
    logic [15:0]   loss_q, loss_d;
`endif

    assign lock_s    = sync_q[1];
    assign pll_reset = pll_reset_q;
    assign pll_psda  = psda_q;
    assign ps_ack    = ack_q;
    assign vid_rst   = vid_rst_q;
    assign locked    = locked_q;
    assign fail      = fail_q;
    assign retry_cnt = retry_q;
`ifdef VIDEO_PLL_LOSS_CNT_EN
    assign lock_loss_cnt = loss_q;
`endif

    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state_q     <= ST_RST_PLL;
            cnt_q       <= '0;
            sync_q      <= '0;
            pll_reset_q <= 1'b1;
            psda_q      <= '0;
            ack_q       <= 1'b0;
            vid_rst_q   <= 1'b1;
            locked_q    <= 1'b0;
            fail_q      <= 1'b0;
            retry_q     <= '0;
            req_done_q  <= 1'b0;
`ifdef VIDEO_PLL_LOSS_CNT_EN
            loss_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sync_q      <= {sync_q[0], pll_lock};
            pll_reset_q <= pll_reset_d;
            psda_q      <= psda_d;
            ack_q       <= ack_d;
            vid_rst_q   <= vid_rst_d;
            locked_q    <= locked_d;
            fail_q      <= fail_d;
            retry_q     <= retry_d;
            req_done_q  <= req_done_d;
`ifdef VIDEO_PLL_LOSS_CNT_EN
            loss_q      <= loss_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pll_reset_d = pll_reset_q;
        psda_d      = psda_q;
        ack_d       = 1'b0;
        vid_rst_d   = vid_rst_q;
        locked_d    = locked_q;
        fail_d      = fail_q;
        retry_d     = retry_q;
        // A served request must drop before the next one is taken.
        req_done_d  = ps_req ? req_done_q : 1'b0;
`ifdef VIDEO_PLL_LOSS_CNT_EN
        loss_d      = loss_q;
`endif

        if (!lock_s && (state_q == ST_RUN || state_q == ST_SETTLE)) begin
            state_d     = ST_RST_PLL;
            cnt_d       = '0;
            pll_reset_d = 1'b1;
            locked_d    = 1'b0;
            vid_rst_d   = 1'b1;
            retry_d     = '0;
`ifdef VIDEO_PLL_LOSS_CNT_EN
            if (loss_q != 16'hFFFF) loss_d = loss_q + 16'd1;
`endif
        end else begin
            unique case (state_q)
                ST_RST_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_d     = ST_WAIT_LOCK;
                        cnt_d       = '0;
                        pll_reset_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        cnt_d = '0;
                        if (LOCK_STABLE == 1) begin
                            state_d   = ST_RUN;
                            locked_d  = 1'b1;
                            vid_rst_d = 1'b0;
                            retry_d   = '0;
                        end else begin
                            state_d = ST_STABLE;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        cnt_d       = '0;
                        pll_reset_d = 1'b1;
                        retry_d     = retry_q + 2'd1;
                        if (retry_d == RETRY_LIM) begin
                            state_d = ST_FAIL;
                            fail_d  = 1'b1;
                        end else begin
                            state_d = ST_RST_PLL;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_STABLE: begin
                    if (!lock_s) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STB_LAST) begin
                        state_d   = ST_RUN;
                        cnt_d     = '0;
                        locked_d  = 1'b1;
                        vid_rst_d = 1'b0;
                        retry_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_RUN: begin
                    if (ps_req && !req_done_q) begin
                        psda_d  = ps_val;
                        state_d = ST_SETTLE;
                        cnt_d   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == SET_LAST) begin
                        ack_d      = 1'b1;
                        req_done_d = 1'b1;
                        state_d    = ST_RUN;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_FAIL: begin
                    pll_reset_d = 1'b1;
                    vid_rst_d   = 1'b1;
                    fail_d      = 1'b1;
                end
                default: begin
                    state_d = ST_RST_PLL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_video_pll_ctrl.sv
// tb_video_pll_ctrl: randomized bench for video_pll_ctrl with a
// cycle-level behavioural model and directed timing checks.
module tb_video_pll_ctrl;

    localparam int RST_C = 4;
    localparam int STB_C = 8;
    localparam int TMO_C = 32;
    localparam int SET_C = 4;
    localparam int RETRY = 2;

    localparam int P_HOLD = 0;
    localparam int P_SEEK = 1;
    localparam int P_RUN  = 2;
    localparam int P_DEAD = 3;

    logic       clkin = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       ps_req;
    logic [3:0] ps_val;
    logic       pll_reset;
    logic [3:0] pll_psda;
    logic       ps_ack;
    logic       vid_rst;
    logic       locked;
    logic       fail;
    logic [1:0] retry_cnt;
`ifdef VIDEO_PLL_LOSS_CNT_EN
    logic [15:0] lock_loss_cnt;
`endif

    video_pll_ctrl #(
        .RST_CYCLES   (RST_C),
        .LOCK_STABLE  (STB_C),
        .LOCK_TIMEOUT (TMO_C),
        .SETTLE_CYCLES(SET_C),
        .MAX_RETRY    (RETRY)
    ) dut (
        .clkin    (clkin),
        .reset    (reset),
        .pll_lock (pll_lock),
        .ps_req   (ps_req),
        .ps_val   (ps_val),
        .pll_reset(pll_reset),
        .pll_psda (pll_psda),
        .ps_ack   (ps_ack),
        .vid_rst  (vid_rst),
        .locked   (locked),
        .fail     (fail),
        .retry_cnt(retry_cnt)
`ifdef VIDEO_PLL_LOSS_CNT_EN
        ,
        .lock_loss_cnt(lock_loss_cnt)
`endif
    );

    always #5 clkin = ~clkin;

    int total = 0;
    int bad   = 0;

    // Model: lock samples pass through a 2-deep delay; phases count down
    // remaining cycles; a streak counts consecutive locked samples.
    int       m_ph;
    int       m_hold_left;
    int       m_elapsed;
    int       m_streak;
    int       m_settle_left;
    int       m_tries;
    int       m_loss;
    bit [3:0] m_psda;
    bit       m_ack;
    bit       m_served;
    bit       m_p1;
    bit       m_p2;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_ph          = P_HOLD;
        m_hold_left   = RST_C;
        m_elapsed     = 0;
        m_streak      = 0;
        m_settle_left = 0;
        m_tries       = 0;
        m_loss        = 0;
        m_psda        = '0;
        m_ack         = 1'b0;
        m_served      = 1'b0;
        m_p1          = 1'b0;
        m_p2          = 1'b0;
    endtask

    task automatic m_edge(input bit lk, input bit rq, input bit [3:0] v);
        bit ls;
        ls    = m_p2;
        m_p2  = m_p1;
        m_p1  = lk;
        m_ack = 1'b0;
        case (m_ph)
            P_HOLD: begin
                m_hold_left--;
                if (m_hold_left == 0) begin
                    m_ph      = P_SEEK;
                    m_elapsed = 0;
                    m_streak  = 0;
                end
            end
            P_SEEK: begin
                if (ls) begin
                    m_streak++;
                    if (m_streak == STB_C) begin
                        m_ph          = P_RUN;
                        m_tries       = 0;
                        m_settle_left = 0;
                    end
                end else if (m_streak > 0) begin
                    m_streak  = 0;
                    m_elapsed = 0;
                end else begin
                    m_elapsed++;
                    if (m_elapsed == TMO_C) begin
                        m_tries++;
                        if (m_tries == RETRY) begin
                            m_ph = P_DEAD;
                        end else begin
                            m_ph        = P_HOLD;
                            m_hold_left = RST_C;
                        end
                    end
                end
            end
            P_RUN: begin
                if (!ls) begin
                    m_ph          = P_HOLD;
                    m_hold_left   = RST_C;
                    m_tries       = 0;
                    m_settle_left = 0;
                    if (m_loss < 65535) m_loss++;
                end else if (m_settle_left > 0) begin
                    m_settle_left--;
                    if (m_settle_left == 0) m_ack = 1'b1;
                end else if (rq && !m_served) begin
                    m_psda        = v;
                    m_settle_left = SET_C;
                end
            end
            default: begin
            end
        endcase
        if (!rq) m_served = 1'b0;
        if (m_ack) m_served = 1'b1;
    endtask

    task automatic cmp_all();
        chk("pll_reset", 32'(pll_reset), 32'(m_ph == P_HOLD || m_ph == P_DEAD));
        chk("pll_psda", 32'(pll_psda), 32'(m_psda));
        chk("ps_ack", 32'(ps_ack), 32'(m_ack));
        chk("vid_rst", 32'(vid_rst), 32'(m_ph != P_RUN));
        chk("locked", 32'(locked), 32'(m_ph == P_RUN));
        chk("fail", 32'(fail), 32'(m_ph == P_DEAD));
        chk("retry_cnt", 32'(retry_cnt), 32'(m_tries));
`ifdef VIDEO_PLL_LOSS_CNT_EN
        chk("lock_loss_cnt", 32'(lock_loss_cnt), 32'(m_loss));
`endif
    endtask

    task automatic cyc();
        @(posedge clkin);
        #1;
        if (reset) m_reset();
        else m_edge(pll_lock, ps_req, ps_val);
        cmp_all();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        m_reset();
        cmp_all();
        repeat (n) cyc();
        reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int n;
        int first_low;
        int seg;
        int hold_ex;
        int dead;

        reset    = 1'b1;
        pll_lock = 1'b0;
        ps_req   = 1'b0;
        ps_val   = 4'h0;
        m_reset();
        @(posedge clkin);
        #1;
        cmp_all();
        @(posedge clkin);
        #1;
        cmp_all();
        reset = 1'b0;

        // Power-up: reset pulse length, then lock latency (sync + window).
        first_low = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (!pll_reset && first_low == 0) first_low = i;
        end
        chk("rst_pulse_len", 32'(first_low), 32'(RST_C));
        pll_lock = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!locked && n < 100);
        chk("lock_latency", 32'(n), 32'(2 + STB_C));

        // Phase step, single ack, no re-ack while request is held.
        ps_val = 4'hA;
        ps_req = 1'b1;
        cyc();
        chk("psda_apply", 32'(pll_psda), 32'hA);
        n = 0;
        do begin cyc(); n++; end while (!ps_ack && n < 20);
        chk("ack_delay", 32'(n), 32'(SET_C));
        repeat (2) begin
            cyc();
            chk("no_reack", 32'(ps_ack), 32'h0);
        end
        ps_req = 1'b0;
        cyc();

        // Lock lost mid-settle: no ack, psda kept, ack after the next RUN.
        ps_req = 1'b1;
        cyc();
        pll_lock = 1'b0;
        n = 0;
        do begin cyc(); n++; end while (locked && n < 20);
        chk("loss_latency", 32'(n), 32'd3);
        chk("psda_kept", 32'(pll_psda), 32'hA);
        chk("loss_pll_reset", 32'(pll_reset), 32'h1);
`ifdef VIDEO_PLL_LOSS_CNT_EN
        chk("loss_cnt_one", 32'(lock_loss_cnt), 32'h1);
`endif
        pll_lock = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!ps_ack && n < 200);
        chk("late_ack_seen", 32'(ps_ack), 32'h1);
        ps_req = 1'b0;
        cyc();

        // One-cycle lock glitch inside the stable window.
        pll_lock = 1'b0;
        do_reset(2);
        repeat (10) cyc();
        pll_lock = 1'b1;
        repeat (6) cyc();
        pll_lock = 1'b0;
        cyc();
        pll_lock = 1'b1;
        n = 0;
        do begin cyc(); n++; end while (!locked && n < 100);
        chk("glitch_relock", 32'(n), 32'(2 + STB_C));

        // No lock at all: two timeouts then sticky FAIL.
        pll_lock = 1'b0;
        do_reset(2);
        n = 0;
        do begin cyc(); n++; end while (!fail && n < 300);
        chk("fail_edges", 32'(n), 32'(RETRY * (RST_C + TMO_C)));
        chk("fail_retry", 32'(retry_cnt), 32'(RETRY));
        for (int i = 0; i < 200; i++) begin
            pll_lock = 1'($urandom);
            cyc();
        end
        chk("fail_hold_reset", 32'(pll_reset), 32'h1);

        // Randomized lock behaviour, phase requests and resets.
        pll_lock = 1'b1;
        do_reset(1);
        seg     = int'($urandom_range(20, 100));
        hold_ex = 0;
        dead    = 0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (ps_req) begin
                if (hold_ex > 0) begin
                    hold_ex--;
                    if (hold_ex == 0) ps_req = 1'b0;
                end else if (m_ack) begin
                    hold_ex = int'($urandom_range(0, 3));
                    if (hold_ex == 0) ps_req = 1'b0;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                ps_req  = 1'b1;
                ps_val  = 4'($urandom);
                hold_ex = 0;
            end
            seg--;
            if (seg <= 0) begin
                pll_lock = ~pll_lock;
                if (pll_lock)
                    seg = int'($urandom_range(10, 150));
                else if ($urandom_range(0, 3) == 0)
                    seg = int'($urandom_range(30, 80));
                else
                    seg = int'($urandom_range(1, 5));
            end
            if (m_ph == P_DEAD) dead++;
            else dead = 0;
            if (dead > 20 || $urandom_range(0, 999) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
                dead = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
